// File: rtl/arf_stack_sequencer_if.sv
// -----------------------------------------------------------------------------
// arf_stack_sequencer_if
//   Bundles the command handshake from the instruction control unit with the
//   control side of the PC/AR/SP address register file and the data memory.
//
//   master : instruction control unit + ARF/memory environment
//   slave  : arf_stack_sequencer
//
//   start, op[2:0]       command request and opcode
//   data_in[15:0]        PUSH operand
//   target[15:0]         CALL/LDPC destination
//   pc_value[15:0]       current PC from ARF OutC
//   mem_data_in[7:0]     memory read data (asynchronous read)
//   busy, done           sequencer status / one-cycle completion pulse
//   pop_data[15:0]       POP/RET result
//   arf_i, arf_fun_sel, arf_reg_sel, arf_out_c_sel, arf_out_d_sel   ARF control
//   mem_ce, mem_wr, mem_data_out                                     memory strobes
// -----------------------------------------------------------------------------
interface arf_stack_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [15:0] data_in;
    logic [15:0] target;
    logic [15:0] pc_value;
    logic [7:0]  mem_data_in;

    logic        busy;
    logic        done;
    logic [15:0] pop_data;
    logic [15:0] arf_i;
    logic [2:0]  arf_fun_sel;
    logic [2:0]  arf_reg_sel;
    logic [1:0]  arf_out_c_sel;
    logic [1:0]  arf_out_d_sel;
    logic        mem_ce;
    logic        mem_wr;
    logic [7:0]  mem_data_out;

    modport master (
        output start, op, data_in, target, pc_value, mem_data_in,
        input  busy, done, pop_data, arf_i, arf_fun_sel, arf_reg_sel,
               arf_out_c_sel, arf_out_d_sel, mem_ce, mem_wr, mem_data_out
    );

    modport slave (
        input  start, op, data_in, target, pc_value, mem_data_in,
        output busy, done, pop_data, arf_i, arf_fun_sel, arf_reg_sel,
               arf_out_c_sel, arf_out_d_sel, mem_ce, mem_wr, mem_data_out
    );
endinterface

// File: rtl/arf_stack_sequencer.sv
// -----------------------------------------------------------------------------
// arf_stack_sequencer
//   Micro-sequencer for multi-cycle stack and PC operations (PUSH, POP, CALL,
//   RET, LDPC, RSTSP). It drives ARF register enables/functions and the
//   memory strobes; the ARF itself does all SP arithmetic (wrapping mod 2^16).
//   The stack grows downward and SP points at the next free byte.
//
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : arf_stack_sequencer_if.slave (command handshake, ARF + memory control)
//
//   All outputs are decodes of the registered state and latched operands.
// -----------------------------------------------------------------------------
module arf_stack_sequencer #(
    parameter logic [15:0] STACK_BASE = 16'h00FF
) (
    input  logic                  clk,
    input  logic                  rst,
    arf_stack_sequencer_if.slave  bus
);

    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_CALL  = 3'b011;
    localparam logic [2:0] OP_RET   = 3'b100;
    localparam logic [2:0] OP_LDPC  = 3'b101;
    localparam logic [2:0] OP_RSTSP = 3'b111;

    localparam logic [2:0] FUN_DEC   = 3'b000;
    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;

    // Active-low register enables: bit2 PC, bit1 AR, bit0 SP.
    localparam logic [2:0] SEL_NONE = 3'b111;
    localparam logic [2:0] SEL_SP   = 3'b110;
    localparam logic [2:0] SEL_PC   = 3'b011;

    typedef enum logic [3:0] {
        IDLE, PSH_LO, PSH_HI, POP_INC, POP_HI, POP_LO,
        CALL_LD, RET_LD, SP_LD, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [15:0] data_q;
    logic [15:0] target_q;
    logic [15:0] pc_q;
    logic [7:0]  hi_q;
    logic [7:0]  lo_q;
    logic [15:0] pop_data_q;
    logic [15:0] push_word;

    logic        busy, done, mem_ce, mem_wr;
    logic [15:0] arf_i;
    logic [2:0]  arf_fun_sel, arf_reg_sel;
    logic [7:0]  mem_data_out;

    // CALL pushes the return address; PUSH pushes the operand.
    assign push_word = (op_q == OP_CALL) ? pc_q : data_q;

    // NOTE: state and operand registers use non-blocking assignments so every
    // flop samples pre-edge values, including mem_data_in decoded from state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand latches are reset too so a sequence abandoned by
            // reset leaves no stale data visible on pop_data or arf_i.
            state      <= IDLE;
            op_q       <= '0;
            data_q     <= '0;
            target_q   <= '0;
            pc_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            pop_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                op_q     <= bus.op;
                data_q   <= bus.data_in;
                target_q <= bus.target;
                pc_q     <= bus.pc_value;
            end
            if (state == POP_HI) begin
                hi_q <= bus.mem_data_in;
            end
            if (state == POP_LO) begin
                lo_q       <= bus.mem_data_in;
                pop_data_q <= {hi_q, bus.mem_data_in};
            end
        end
    end

    // NOTE: every output and the next state get a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt    = state;
        busy         = (state != IDLE);
        done         = 1'b0;
        arf_i        = '0;
        arf_fun_sel  = FUN_DEC;
        arf_reg_sel  = SEL_NONE;
        mem_ce       = 1'b0;
        mem_wr       = 1'b0;
        mem_data_out = '0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_PUSH, OP_CALL: state_nxt = PSH_LO;
                        OP_POP,  OP_RET:  state_nxt = POP_INC;
                        OP_LDPC:          state_nxt = CALL_LD;
                        OP_RSTSP:         state_nxt = SP_LD;
                        default:          state_nxt = DONE;
                    endcase
                end
            end
            // Write at the current SP; the ARF decrements SP at the same edge.
            PSH_LO: begin
                mem_ce       = 1'b1;
                mem_wr       = 1'b1;
                mem_data_out = push_word[7:0];
                arf_reg_sel  = SEL_SP;
                arf_fun_sel  = FUN_DEC;
                state_nxt    = PSH_HI;
            end
            PSH_HI: begin
                mem_ce       = 1'b1;
                mem_wr       = 1'b1;
                mem_data_out = push_word[15:8];
                arf_reg_sel  = SEL_SP;
                arf_fun_sel  = FUN_DEC;
                state_nxt    = (op_q == OP_CALL) ? CALL_LD : DONE;
            end
            // SP points at a free byte, so step onto the high byte first.
            POP_INC: begin
                arf_reg_sel = SEL_SP;
                arf_fun_sel = FUN_INC;
                state_nxt   = POP_HI;
            end
            POP_HI: begin
                mem_ce      = 1'b1;
                arf_reg_sel = SEL_SP;
                arf_fun_sel = FUN_INC;
                state_nxt   = POP_LO;
            end
            // SP is left on the low byte, which is now the next free byte.
            POP_LO: begin
                mem_ce    = 1'b1;
                state_nxt = (op_q == OP_RET) ? RET_LD : DONE;
            end
            CALL_LD: begin
                arf_reg_sel = SEL_PC;
                arf_fun_sel = FUN_LOAD;
                arf_i       = target_q;
                state_nxt   = DONE;
            end
            RET_LD: begin
                arf_reg_sel = SEL_PC;
                arf_fun_sel = FUN_LOAD;
                arf_i       = {hi_q, lo_q};
                state_nxt   = DONE;
            end
            SP_LD: begin
                arf_reg_sel = SEL_SP;
                arf_fun_sel = FUN_LOAD;
                arf_i       = STACK_BASE;
                state_nxt   = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.pop_data      = pop_data_q;
    assign bus.arf_i         = arf_i;
    assign bus.arf_fun_sel   = arf_fun_sel;
    assign bus.arf_reg_sel   = arf_reg_sel;
    assign bus.arf_out_c_sel = 2'b00;
    assign bus.arf_out_d_sel = 2'b11;
    assign bus.mem_ce        = mem_ce;
    assign bus.mem_wr        = mem_wr;
    assign bus.mem_data_out  = mem_data_out;

endmodule

// File: tb/tb_arf_stack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_arf_stack_sequencer
//   Directed bench for arf_stack_sequencer. A small behavioural ARF (PC/SP)
//   and byte memory respond to the sequencer's strobes; expected values are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_arf_stack_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arf_stack_sequencer_if bus ();

    arf_stack_sequencer #(.STACK_BASE(16'h00FF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- environment: ARF (PC, SP) + byte memory ----------------
    logic [15:0] sp, pc;
    logic [7:0]  mem [0:65535];
    logic [23:0] wr_log [$];
    logic [15:0] rd_log [$];
    int          bad_enable = 0;

    function automatic logic [15:0] arf_op(input logic [15:0] r, input logic [2:0] f,
                                           input logic [15:0] d);
        case (f)
            3'b000:  return r - 16'd1;
            3'b001:  return r + 16'd1;
            3'b010:  return d;
            3'b011:  return 16'h0000;
            default: return r;
        endcase
    endfunction

    assign bus.mem_data_in = (bus.mem_ce && !bus.mem_wr && bus.arf_out_d_sel == 2'b11)
                             ? mem[sp] : 8'h00;

    always @(posedge clk) begin
        if (!bus.arf_reg_sel[0]) sp <= arf_op(sp, bus.arf_fun_sel, bus.arf_i);
        if (!bus.arf_reg_sel[2]) pc <= arf_op(pc, bus.arf_fun_sel, bus.arf_i);
        if (!bus.arf_reg_sel[1]) bad_enable++;
        if ((3 - $countones(bus.arf_reg_sel)) > 1) bad_enable++;
        if (bus.mem_ce && bus.mem_wr) begin
            mem[sp] <= bus.mem_data_out;
            wr_log.push_back({sp, bus.mem_data_out});
        end
        if (bus.mem_ce && !bus.mem_wr) rd_log.push_back(sp);
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},       bus.busy, 0);
        check({tag, " done"},       bus.done, 0);
        check({tag, " pop_data"},   bus.pop_data, 0);
        check({tag, " arf_i"},      bus.arf_i, 0);
        check({tag, " fun_sel"},    bus.arf_fun_sel, 3'b000);
        check({tag, " reg_sel"},    bus.arf_reg_sel, 3'b111);
        check({tag, " out_c_sel"},  bus.arf_out_c_sel, 2'b00);
        check({tag, " out_d_sel"},  bus.arf_out_d_sel, 2'b11);
        check({tag, " mem_ce"},     bus.mem_ce, 0);
        check({tag, " mem_wr"},     bus.mem_wr, 0);
        check({tag, " mem_dout"},   bus.mem_data_out, 0);
    endtask

    // Issue one command and follow it until busy drops (bounded).
    int          busy_n, done_n, done_at;
    logic [15:0] first_i;
    logic [2:0]  first_reg, first_fun;
    logic        saw_act;

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [15:0] din,
                           input logic [15:0] tgt, input logic [15:0] pcv);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.data_in  = din;
        bus.target   = tgt;
        bus.pc_value = pcv;
        @(negedge clk);
        bus.start = 1'b0;
        busy_n    = 0;
        done_n    = 0;
        done_at   = 0;
        saw_act   = 1'b0;
        first_i   = bus.arf_i;
        first_reg = bus.arf_reg_sel;
        first_fun = bus.arf_fun_sel;
        for (int c = 0; c < 20; c++) begin
            if (!bus.busy) break;
            busy_n++;
            if (bus.done) begin
                done_n++;
                done_at = busy_n;
            end
            if (bus.mem_ce || bus.arf_reg_sel != 3'b111) saw_act = 1'b1;
            @(negedge clk);
        end
        check({tag, " returns idle"}, bus.busy, 0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        sp           = 16'h1234;
        pc           = 16'h0000;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 3'b000;
        bus.data_in  = 16'h0000;
        bus.target   = 16'h0000;
        bus.pc_value = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // RSTSP
        run_cmd("rstsp", 3'b111, 16'h0, 16'h0, 16'h0);
        check("rstsp arf_i", first_i, 16'h00FF);
        check("rstsp reg_sel", first_reg, 3'b110);
        check("rstsp fun_sel", first_fun, 3'b010);
        check("rstsp busy cycles", busy_n, 2);
        check("rstsp done count", done_n, 1);
        check("rstsp done at", done_at, 2);
        check("rstsp sp", sp, 16'h00FF);

        // PUSH 0xBEEF
        wr_log.delete();
        run_cmd("push", 3'b001, 16'hBEEF, 16'h0, 16'h0);
        check("push busy cycles", busy_n, 3);
        check("push done count", done_n, 1);
        check("push writes", wr_log.size(), 2);
        check("push write0", wr_log[0], 24'h00FFEF);
        check("push write1", wr_log[1], 24'h00FEBE);
        check("push sp", sp, 16'h00FD);

        // POP
        rd_log.delete();
        run_cmd("pop", 3'b010, 16'h0, 16'h0, 16'h0);
        check("pop busy cycles", busy_n, 4);
        check("pop done at", done_at, 4);
        check("pop done count", done_n, 1);
        check("pop reads", rd_log.size(), 2);
        check("pop read0", rd_log[0], 16'h00FE);
        check("pop read1", rd_log[1], 16'h00FF);
        check("pop data", bus.pop_data, 16'hBEEF);
        check("pop sp", sp, 16'h00FF);

        // CALL 0x0200 from PC 0x0034
        wr_log.delete();
        run_cmd("call", 3'b011, 16'h0, 16'h0200, 16'h0034);
        check("call busy cycles", busy_n, 4);
        check("call write0", wr_log[0], 24'h00FF34);
        check("call write1", wr_log[1], 24'h00FE00);
        check("call pc", pc, 16'h0200);
        check("call sp", sp, 16'h00FD);

        // RET
        run_cmd("ret", 3'b100, 16'h0, 16'h0, 16'h0);
        check("ret busy cycles", busy_n, 5);
        check("ret pc", pc, 16'h0034);
        check("ret sp", sp, 16'h00FF);
        check("ret pop_data", bus.pop_data, 16'h0034);

        // Illegal op 110
        run_cmd("illegal", 3'b110, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        check("illegal busy cycles", busy_n, 1);
        check("illegal done count", done_n, 1);
        check("illegal no activity", saw_act, 0);
        check("illegal pop_data held", bus.pop_data, 16'h0034);
        check("illegal pc", pc, 16'h0034);
        check("illegal sp", sp, 16'h00FF);

        // Start held high while busy (and in DONE) is ignored
        wr_log.delete();
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = 3'b001;
        bus.data_in = 16'h1234;
        @(negedge clk);                 // PSH_LO
        bus.op = 3'b111;
        check("ignore busy psh_lo", bus.busy, 1);
        @(negedge clk);                 // PSH_HI
        @(negedge clk);                 // DONE
        check("ignore done pulse", bus.done, 1);
        @(negedge clk);                 // IDLE
        bus.start = 1'b0;
        check("ignore back idle", bus.busy, 0);
        @(negedge clk);
        check("ignore stays idle", bus.busy, 0);
        check("ignore sp", sp, 16'h00FD);
        check("ignore writes", wr_log.size(), 2);
        check("ignore write0", wr_log[0], 24'h00FF34);
        check("ignore write1", wr_log[1], 24'h00FE12);

        // Reset during POP_HI
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b010;
        @(negedge clk);                 // POP_INC
        bus.start = 1'b0;
        @(negedge clk);                 // POP_HI
        check("abort in pop_hi", bus.mem_ce, 1);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'b001;
        @(negedge clk);
        check_idle("abort");
        check("abort sp partial", sp, 16'h00FF);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("abort stays idle", bus.busy, 0);
        check("abort no strobe", bus.mem_ce, 0);

        // New commands after reset are accepted
        run_cmd("ldpc", 3'b101, 16'h0, 16'h0ABC, 16'h0);
        check("ldpc busy cycles", busy_n, 2);
        check("ldpc arf_i", first_i, 16'h0ABC);
        check("ldpc reg_sel", first_reg, 3'b011);
        check("ldpc pc", pc, 16'h0ABC);
        check("ldpc sp", sp, 16'h00FF);

        run_cmd("rstsp2", 3'b111, 16'h0, 16'h0, 16'h0);
        check("rstsp2 busy cycles", busy_n, 2);
        check("rstsp2 sp", sp, 16'h00FF);

        // AR never enabled; at most one register enabled per cycle
        check("enable rule violations", bad_enable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arf_stack_sequencer.md
Name: arf_stack_sequencer

Overview:
- Micro-sequencer that drives the control side of the PC/AR/SP address register file (ARF) and a byte-wide data memory.
- Executes multi-cycle stack and PC operations: PUSH, POP, CALL, RET, LDPC and RSTSP.
- Generates ARF RegSel/FunSel/OutCSel/OutDSel/I and memory strobes.
- Sits between the instruction control unit (Start/Op handshake) and the ARF + memory.

Parameters:
- STACK_BASE, 16'h00FF, value loaded into SP by RSTSP.

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  command request; honoured only in IDLE
- Op  in  3  command: 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 LDPC, 111 RSTSP; 000/110 illegal
- DataIn  in  16  PUSH operand
- Target  in  16  CALL/LDPC destination
- PCValue  in  16  current PC (ARF OutC, OutCSel held 00)
- MemDataIn  in  8  memory read data (asynchronous read, valid same cycle)
- Busy  out  1  high in every non-IDLE state
- Done  out  1  one-cycle completion pulse
- PopData  out  16  POP result; held until next accepted command
- ARF_I  out  16  ARF load data
- ARF_FunSel  out  3  000 dec, 001 inc, 010 load, 011 clear
- ARF_RegSel  out  3  active-low enables, bit2 PC, bit1 AR, bit0 SP; 111 = none
- ARF_OutCSel  out  2  constant 00 (PC)
- ARF_OutDSel  out  2  memory address select; 11 (SP) during stack states
- MemCE  out  1  memory chip enable, active-high
- MemWR  out  1  1 = write, 0 = read
- MemDataOut  out  8  memory write data

Behaviour:
- Reset (sync, any state): state IDLE; Busy=0, Done=0, PopData=0, ARF_I=0, ARF_FunSel=000, ARF_RegSel=111, ARF_OutCSel=00, ARF_OutDSel=11, MemCE=0, MemWR=0, MemDataOut=0; internal latches cleared.
- Reset mid-operation: the sequence is abandoned. No further ARF enable or memory strobe is issued; partial SP changes stand.
- Outputs are registered-state decodes. Every non-listed output keeps its idle value.
- IDLE + Start: latch Op, DataIn, Target and PCValue. Go to the first state of the Op. Start while Busy is ignored.
- Stack layout: the stack grows downward. SP points at the next free byte. PUSH writes the low byte at SP, then the high byte at SP-1.
- PSH_LO: MemCE=1, MemWR=1, MemDataOut=lo, OutDSel=11, RegSel=110, FunSel=000 (write at old SP, SP decrements at the edge).
- PSH_HI: same as PSH_LO with MemDataOut=hi.
- POP_INC: RegSel=110, FunSel=001.
- POP_HI: MemCE=1, MemWR=0, OutDSel=11; latch hi=MemDataIn; SP increments.
- POP_LO: MemCE=1, MemWR=0, OutDSel=11; latch lo; SP unchanged.
- PUSH: PSH_LO -> PSH_HI -> DONE (Busy 3 cycles).
- POP: POP_INC -> POP_HI -> POP_LO -> DONE. PopData={hi,lo} updates on entry to DONE.
- CALL: PSH_LO/PSH_HI with the latched PCValue -> CALL_LD (RegSel=011, FunSel=010, ARF_I=Target) -> DONE.
- RET: POP states -> RET_LD (RegSel=011, FunSel=010, ARF_I={hi,lo}) -> DONE. PopData also updates.
- LDPC: CALL_LD -> DONE.
- RSTSP: SP_LD (RegSel=110, FunSel=010, ARF_I=STACK_BASE) -> DONE.
- Illegal Op: DONE directly. No ARF or memory activity.
- DONE: Done=1, Busy=1, then IDLE. A Start seen in DONE is ignored.
- Only one ARF register is enabled per cycle. AR (RegSel bit1) is never enabled.
- SP arithmetic is performed by the ARF and wraps modulo 2^16 (0x0000 dec -> 0xFFFF). The sequencer does no overflow detection.

Test Plan:
- Reset, RSTSP -> SP_LD cycle with ARF_I=0x00FF, RegSel=110, FunSel=010; Done pulses 2 cycles after Start; SP model = 0x00FF.
- PUSH 0xBEEF with SP=0x00FF -> write 0xEF @0x00FF, then 0xBE @0x00FE; SP=0x00FD; Busy 3 cycles; single Done.
- POP after that PUSH -> reads @0x00FE then 0x00FF; PopData=0xBEEF; SP=0x00FF; Done on the 4th busy cycle.
- CALL Target=0x0200, PCValue=0x0034, SP=0x00FF -> memory 0x34 @0x00FF, 0x00 @0x00FE; PC=0x0200, SP=0x00FD.
- RET -> PC=0x0034, SP=0x00FF. Then illegal Op 110 -> Done next cycle with no MemCE or RegSel!=111.
- Assert Reset during POP_HI -> next cycle all outputs at idle values, Busy=0; a Start pulsed while Busy is ignored; new Start after reset is accepted.
